sfr_access_arb: RTL and testbench
=================================

# sfr_access_arb

Two-port access controller that sequences and shares the single read/write port of the SFR map between the CPU core (port 0) and the on-chip peripheral/hardware-update path (port 1). It runs round-robin arbitration with a valid/ready request handshake and registers the winning request onto the SFR map's write/read strobes. It returns read data with a fixed latency, and supports a locked (atomic read-modify-write) ownership mode with a timeout.

## Interface
Parameters:
- SFR_WIDTH, 32, SFR data width
- ADDR_WIDTH, 8, SFR word address width
- LOCK_TMO, 16, idle cycles a lock owner may hold the port without a request before forced release (must be ≥ 2)

Ports:
- sys_clk  in  1  system clock, single clock domain
- sys_rst  in  1  synchronous, active-high reset
- sys_clk_en  in  1  clock enable; low = all state holds
- req_valid  in  2  per-port request valid
- req_we  in  2  per-port write (1) / read (0)
- req_lock  in  2  per-port lock-hold request
- req_addr  in  2×ADDR_WIDTH  per-port address, port p at [p*ADDR_WIDTH +: ADDR_WIDTH]
- req_wdata  in  2×SFR_WIDTH  per-port write data, same packing
- req_ready  out  2  request accepted this cycle
- rsp_valid  out  2  one-cycle completion pulse to the owning port
- rsp_rdata  out  SFR_WIDTH  read data, shared, qualified by rsp_valid
- lock_err  out  1  one-cycle pulse on lock timeout release
- sfr_wen  out  1  SFR map write strobe
- sfr_ren  out  1  SFR map read strobe
- sfr_addr  out  ADDR_WIDTH  SFR map address
- sfr_din  out  SFR_WIDTH  SFR map write data
- sfr_dout  in  SFR_WIDTH  SFR map read data, valid the cycle after sfr_ren

## Operation
- FSM states: IDLE, ACCESS, RDWAIT, LOCKED.
- **IDLE**
  - The arbiter picks a winner among asserted req_valid bits that are eligible.
  - req_ready[winner] is asserted combinationally in the same cycle.
  - The winner's we/lock/addr/wdata and index are registered, and the FSM moves to ACCESS.
- **Round robin**
  - rr_last records the last granted port.
  - On simultaneous valid, the port ≠ rr_last wins. With a single valid, that port wins.
- **ACCESS**
  - Drives sfr_addr and sfr_din, and pulses sfr_wen (write) or sfr_ren (read) for exactly one cycle.
  - Write: rsp_valid[owner] pulses in this same cycle with rsp_rdata = 0.
  - Write next state: LOCKED if the registered lock = 1, else IDLE.
  - Read: next state is RDWAIT.
- **RDWAIT**
  - rsp_valid[owner] pulses with rsp_rdata = sfr_dout.
  - Next state: LOCKED if lock = 1, else IDLE.
- **LOCKED**
  - Only the owner is eligible. req_ready of the other port is forced 0.
  - An owner request is accepted exactly as in IDLE.
  - An accepted request with req_lock = 0 releases the lock after it completes.
  - The tmo counter increments each enabled cycle without an owner request and clears on acceptance.
  - When tmo reaches LOCK_TMO−1: go to IDLE, pulse lock_err, clear the owner.
- **sys_clk_en low**
  - All registers hold.
  - req_ready, rsp_valid, sfr_wen, sfr_ren and lock_err are gated to 0.
  - The operation resumes unchanged when sys_clk_en returns high.
- **Reset**
  - sys_rst dominates sys_clk_en.
  - A transaction in flight is dropped: no rsp_valid is issued and the lock is cleared.

## Timing
- Reset values:
  - state IDLE, rr_last = 1 (port 0 wins first), tmo = 0, owner = 0.
  - All outputs 0.
- Write latency: accept at cycle N, sfr_wen and rsp_valid at N+1, next accept possible at N+2.
- Read latency: accept at N, sfr_ren at N+1, rsp_valid with data at N+2, next accept possible at N+3.
- At most one transaction is outstanding. req_ready is 0 in ACCESS and RDWAIT.
- Requesters hold valid/addr/wdata stable until ready. Dropping valid before ready is permitted; no side effect.
- Exactly one rsp_valid pulse per accepted request, barring reset.

## Structure
- Package sfr_pkg holds:
  - the typedef enum for the arbiter state (IDLE, ACCESS, RDWAIT, LOCKED)
  - the constants REQ_CPU = 0 and REQ_PERIPH = 1
  - the shared SFR_WIDTH and ADDR_WIDTH defaults
- Sub-module sfr_rr_arb2 holds the 2-way round-robin picker:
  - inputs: valid[1:0], eligible mask, rr_last
  - outputs: grant one-hot, grant index
  - purely combinational
- FSM, request register, tmo counter and output gating live in the top.

## Test plan
- **Single write:** after reset, port 0 writes addr 0x10 data 0xDEADBEEF. Expect ready at cycle N, sfr_wen = 1, sfr_addr = 0x10, sfr_din = 0xDEADBEEF and rsp_valid = 01 at N+1.
- **Read:** port 1 reads 0x04 and the SFR model returns 0x12345678. Expect sfr_ren at N+1 and rsp_valid = 10 with rsp_rdata = 0x12345678 at N+2.
- **Contention:** both ports hold valid continuously. Expect grants ordered 0,1,0,1 and no port granted twice in a row.
- **Lock:**
  - Port 1 issues a read with lock = 1 while port 0 is valid. Expect port 0 ready = 0 until port 1 issues a write with lock = 0 to the same address.
  - Then expect port 0 to be granted next.
- **Lock timeout:** port 0 locks, then stays idle with LOCK_TMO = 16. Expect lock_err to pulse once, 16 cycles after completion entered LOCKED, and port 1 then granted.
- **Enable/reset:**
  - Deassert sys_clk_en during RDWAIT for 3 cycles. Expect no strobes, then rsp_valid after re-enable with correct data.
  - Assert sys_rst in ACCESS. Expect no rsp_valid and all outputs 0 next cycle.

Source files
------------

// File: rtl/sfr_pkg.sv
// Shared types and defaults for the SFR access arbiter.
package sfr_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RDWAIT = 2'd2,
        LOCKED = 2'd3
    } arb_state_e;

    localparam logic REQ_CPU    = 1'b0;
    localparam logic REQ_PERIPH = 1'b1;

    localparam int SFR_WIDTH_DFLT  = 32;
    localparam int ADDR_WIDTH_DFLT = 8;

endpackage

// File: rtl/sfr_rr_arb2.sv
// Two-way round-robin picker: on a tie the port that was not granted last wins.
module sfr_rr_arb2
    import sfr_pkg::*;
(
    input  logic [1:0] valid,
    input  logic [1:0] eligible,
    input  logic       rr_last,
    output logic [1:0] grant_oh,
    output logic       grant_idx
);

    logic [1:0] cand_s;

    // Candidate filtering and tie-break
    always_comb begin
        cand_s    = valid & eligible;
        grant_oh  = 2'b00;
        grant_idx = REQ_CPU;
        case (cand_s)
            2'b01: begin
                grant_oh  = 2'b01;
                grant_idx = REQ_CPU;
            end
            2'b10: begin
                grant_oh  = 2'b10;
                grant_idx = REQ_PERIPH;
            end
            2'b11: begin
                grant_idx = ~rr_last;
                grant_oh  = rr_last ? 2'b01 : 2'b10;
            end
            default: begin
                grant_oh  = 2'b00;
                grant_idx = REQ_CPU;
            end
        endcase
    end

endmodule

// File: rtl/sfr_access_arb.sv
// Shares the single SFR map port between CPU (port 0) and peripheral path (port 1),
// with round-robin arbitration, fixed-latency read return and a timed lock mode.
module sfr_access_arb
    import sfr_pkg::*;
#(
    parameter int SFR_WIDTH  = SFR_WIDTH_DFLT,
    parameter int ADDR_WIDTH = ADDR_WIDTH_DFLT,
    parameter int LOCK_TMO   = 16
) (
    input  logic                    sys_clk,
    input  logic                    sys_rst,
    input  logic                    sys_clk_en,
    input  logic [1:0]              req_valid,
    input  logic [1:0]              req_we,
    input  logic [1:0]              req_lock,
    input  logic [2*ADDR_WIDTH-1:0] req_addr,
    input  logic [2*SFR_WIDTH-1:0]  req_wdata,
    output logic [1:0]              req_ready,
    output logic [1:0]              rsp_valid,
    output logic [SFR_WIDTH-1:0]    rsp_rdata,
    output logic                    lock_err,
    output logic                    sfr_wen,
    output logic                    sfr_ren,
    output logic [ADDR_WIDTH-1:0]   sfr_addr,
    output logic [SFR_WIDTH-1:0]    sfr_din,
    input  logic [SFR_WIDTH-1:0]    sfr_dout
);

    localparam int TMO_W = $clog2(LOCK_TMO);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(LOCK_TMO - 1);

    arb_state_e             state_q, state_d;
    logic                   rr_last_q, rr_last_d;
    logic                   owner_q, owner_d;
    logic                   we_q, we_d;
    logic                   lock_q, lock_d;
    logic [ADDR_WIDTH-1:0]  addr_q, addr_d;
    logic [SFR_WIDTH-1:0]   wdata_q, wdata_d;
    logic [TMO_W-1:0]       tmo_q, tmo_d;
    logic                   lock_err_q, lock_err_d;

    logic [1:0] eligible_s;
    logic [1:0] grant_oh_s;
    logic       grant_idx_s;
    logic       grant_any_s;
    logic [1:0] owner_oh_s;
    logic       act_s;

    sfr_rr_arb2 u_arb (
        .valid     (req_valid),
        .eligible  (eligible_s),
        .rr_last   (rr_last_q),
        .grant_oh  (grant_oh_s),
        .grant_idx (grant_idx_s)
    );

    assign grant_any_s = |grant_oh_s;
    assign owner_oh_s  = owner_q ? 2'b10 : 2'b01;
    // Pulses and handshakes are suppressed while stalled or in reset.
    assign act_s       = sys_clk_en & ~sys_rst;

    // Only IDLE accepts anyone; LOCKED accepts the owner alone.
    always_comb begin
        eligible_s = 2'b00;
        case (state_q)
            IDLE:    eligible_s = 2'b11;
            LOCKED:  eligible_s = owner_oh_s;
            default: eligible_s = 2'b00;
        endcase
    end

    // Next-state, request capture and lock timeout
    always_comb begin
        state_d    = state_q;
        rr_last_d  = rr_last_q;
        owner_d    = owner_q;
        we_d       = we_q;
        lock_d     = lock_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        tmo_d      = tmo_q;
        lock_err_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (grant_any_s) begin
                    state_d = ACCESS;
                end else begin
                    state_d = IDLE;
                end
            end
            ACCESS: begin
                if (we_q) begin
                    state_d = lock_q ? LOCKED : IDLE;
                end else begin
                    state_d = RDWAIT;
                end
            end
            RDWAIT: begin
                state_d = lock_q ? LOCKED : IDLE;
            end
            LOCKED: begin
                if (grant_any_s) begin
                    state_d = ACCESS;
                end else if (tmo_q == TMO_LAST) begin
                    state_d    = IDLE;
                    tmo_d      = {TMO_W{1'b0}};
                    owner_d    = REQ_CPU;
                    lock_d     = 1'b0;
                    lock_err_d = 1'b1;
                end else begin
                    tmo_d = tmo_q + TMO_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (grant_any_s) begin
            rr_last_d = grant_idx_s;
            owner_d   = grant_idx_s;
            we_d      = req_we[grant_idx_s];
            lock_d    = req_lock[grant_idx_s];
            addr_d    = grant_idx_s ? req_addr[2*ADDR_WIDTH-1:ADDR_WIDTH]
                                    : req_addr[ADDR_WIDTH-1:0];
            wdata_d   = grant_idx_s ? req_wdata[2*SFR_WIDTH-1:SFR_WIDTH]
                                    : req_wdata[SFR_WIDTH-1:0];
            tmo_d     = {TMO_W{1'b0}};
        end else begin
            rr_last_d = rr_last_d;
        end
    end

    // State registers; clock enable low freezes everything
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state_q    <= IDLE;
            rr_last_q  <= REQ_PERIPH;
            owner_q    <= REQ_CPU;
            we_q       <= 1'b0;
            lock_q     <= 1'b0;
            addr_q     <= {ADDR_WIDTH{1'b0}};
            wdata_q    <= {SFR_WIDTH{1'b0}};
            tmo_q      <= {TMO_W{1'b0}};
            lock_err_q <= 1'b0;
        end else if (sys_clk_en) begin
            state_q    <= state_d;
            rr_last_q  <= rr_last_d;
            owner_q    <= owner_d;
            we_q       <= we_d;
            lock_q     <= lock_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            tmo_q      <= tmo_d;
            lock_err_q <= lock_err_d;
        end
    end

    assign req_ready = grant_oh_s & {2{act_s}};
    assign rsp_valid = (act_s && ((state_q == ACCESS && we_q) || state_q == RDWAIT))
                       ? owner_oh_s : 2'b00;
    assign rsp_rdata = (act_s && state_q == RDWAIT) ? sfr_dout : {SFR_WIDTH{1'b0}};
    assign sfr_wen   = act_s & (state_q == ACCESS) & we_q;
    assign sfr_ren   = act_s & (state_q == ACCESS) & ~we_q;
    assign sfr_addr  = addr_q;
    assign sfr_din   = wdata_q;
    assign lock_err  = act_s & lock_err_q;

endmodule

// File: tb/tb_sfr_access_arb.sv
// Directed bench for sfr_access_arb with a small SFR memory model.
module tb_sfr_access_arb;

    logic        sys_clk = 1'b0;
    logic        sys_rst;
    logic        sys_clk_en;
    logic [1:0]  req_valid, req_we, req_lock;
    logic [15:0] req_addr;
    logic [63:0] req_wdata;
    logic [1:0]  req_ready, rsp_valid;
    logic [31:0] rsp_rdata;
    logic        lock_err, sfr_wen, sfr_ren;
    logic [7:0]  sfr_addr;
    logic [31:0] sfr_din;
    logic [31:0] sfr_dout;

    logic [31:0] mem [256];
    int n_vec = 0;
    int n_err = 0;

    always #5 sys_clk = ~sys_clk;

    sfr_access_arb #(.SFR_WIDTH(32), .ADDR_WIDTH(8), .LOCK_TMO(16)) dut (
        .sys_clk(sys_clk), .sys_rst(sys_rst), .sys_clk_en(sys_clk_en),
        .req_valid(req_valid), .req_we(req_we), .req_lock(req_lock),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_ready(req_ready),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .lock_err(lock_err),
        .sfr_wen(sfr_wen), .sfr_ren(sfr_ren), .sfr_addr(sfr_addr),
        .sfr_din(sfr_din), .sfr_dout(sfr_dout)
    );

    // SFR map model: synchronous write, one-cycle read
    always @(posedge sys_clk) begin
        if (sfr_wen) mem[sfr_addr] <= sfr_din;
        if (sfr_ren) sfr_dout <= mem[sfr_addr];
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_ready"}, 64'(req_ready), 64'h0);
        check({tag, "_rspv"},  64'(rsp_valid), 64'h0);
        check({tag, "_rdata"}, 64'(rsp_rdata), 64'h0);
        check({tag, "_strb"},  64'({lock_err, sfr_wen, sfr_ren}), 64'h0);
        check({tag, "_addr"},  64'(sfr_addr), 64'h0);
        check({tag, "_din"},   64'(sfr_din), 64'h0);
    endtask

    logic [1:0] exp_oh [4];

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 32'h0;
        mem[8'h04] = 32'h12345678;
        mem[8'h20] = 32'hCAFEF00D;
        sfr_dout   = 32'h0;
        sys_rst = 1'b1; sys_clk_en = 1'b1;
        req_valid = 2'b00; req_we = 2'b00; req_lock = 2'b00;
        req_addr = 16'h0; req_wdata = 64'h0;
        exp_oh[0] = 2'b01; exp_oh[1] = 2'b10; exp_oh[2] = 2'b01; exp_oh[3] = 2'b10;

        cyc(); cyc(); #1;
        check_all_zero("reset");

        // Single write from port 0
        cyc(); sys_rst = 1'b0;
        req_valid = 2'b01; req_we = 2'b01; req_addr = 16'h0010; req_wdata = {32'h0, 32'hDEADBEEF};
        #1 check("wr_ready", 64'(req_ready), 64'h1);
        cyc(); req_valid = 2'b00;
        #1 check("wr_wen", 64'(sfr_wen), 64'h1);
        check("wr_addr", 64'(sfr_addr), 64'h10);
        check("wr_din", 64'(sfr_din), 64'hDEADBEEF);
        check("wr_rspv", 64'(rsp_valid), 64'h1);
        check("wr_rdata", 64'(rsp_rdata), 64'h0);

        // Read from port 1
        cyc(); req_valid = 2'b10; req_we = 2'b00; req_addr = 16'h0400;
        #1 check("rd_ready", 64'(req_ready), 64'h2);
        cyc(); req_valid = 2'b00;
        #1 check("rd_ren", 64'({sfr_ren, sfr_wen}), 64'h2);
        check("rd_addr", 64'(sfr_addr), 64'h04);
        check("rd_norsp", 64'(rsp_valid), 64'h0);
        cyc(); #1;
        check("rd_rspv", 64'(rsp_valid), 64'h2);
        check("rd_rdata", 64'(rsp_rdata), 64'h12345678);

        // Contention: both writes held valid
        for (int i = 0; i < 4; i++) begin
            cyc(); req_valid = 2'b11; req_we = 2'b11;
            req_addr = {8'(8'h61 + i), 8'(8'h60 + i)};
            req_wdata = {32'(i + 100), 32'(i + 200)};
            #1 check("rr_ready", 64'(req_ready), 64'(exp_oh[i]));
            cyc(); if (i == 3) req_valid = 2'b00;
            #1 check("rr_rspv", 64'(rsp_valid), 64'(exp_oh[i]));
            check("rr_busy", 64'(req_ready), 64'h0);
        end

        // Port 0 write so port 1 is next in round-robin order
        cyc(); req_valid = 2'b01; req_we = 2'b01; req_addr = 16'h0030; req_wdata = {32'h0, 32'hA5A5A5A5};
        #1 check("pre_ready", 64'(req_ready), 64'h1);
        cyc(); req_valid = 2'b00;
        #1 check("pre_wen", 64'(sfr_wen), 64'h1);

        // Lock: port 1 locked read, port 0 waiting
        cyc(); req_valid = 2'b11; req_we = 2'b01; req_lock = 2'b10;
        req_addr = 16'h2040; req_wdata = {32'h0, 32'h11111111};
        #1 check("lk_ready", 64'(req_ready), 64'h2);
        cyc(); req_valid = 2'b01; req_lock = 2'b00;
        #1 check("lk_ren", 64'({sfr_ren, req_ready}), 64'h4);
        check("lk_addr", 64'(sfr_addr), 64'h20);
        cyc(); #1;
        check("lk_rspv", 64'(rsp_valid), 64'h2);
        check("lk_rdata", 64'(rsp_rdata), 64'hCAFEF00D);
        for (int k = 0; k < 3; k++) begin
            cyc(); #1 check("lk_hold", 64'(req_ready), 64'h0);
        end
        cyc(); req_valid = 2'b11; req_we = 2'b11; req_lock = 2'b00;
        req_wdata = {32'hCAFEF00E, 32'h11111111};
        #1 check("lk_rel_ready", 64'(req_ready), 64'h2);
        cyc(); req_valid = 2'b01;
        #1 check("lk_rel_wen", 64'({sfr_wen, rsp_valid}), 64'h6);
        check("lk_rel_din", 64'(sfr_din), 64'hCAFEF00E);
        cyc(); #1 check("lk_p0_ready", 64'(req_ready), 64'h1);
        cyc(); req_valid = 2'b00;
        #1 check("lk_p0_rspv", 64'(rsp_valid), 64'h1);
        check("lk_p0_addr", 64'(sfr_addr), 64'h40);

        // Lock timeout: port 0 locks and goes quiet, port 1 waits
        cyc(); req_valid = 2'b01; req_we = 2'b01; req_lock = 2'b01; req_addr = 16'h0450;
        #1 check("to_ready", 64'(req_ready), 64'h1);
        cyc(); req_valid = 2'b00; req_lock = 2'b00;
        #1 check("to_rspv", 64'(rsp_valid), 64'h1);
        cyc(); req_valid = 2'b10; req_we = 2'b00;
        #1 check("to_l0", 64'({lock_err, req_ready}), 64'h0);
        for (int k = 1; k < 16; k++) begin
            cyc(); #1 check("to_wait", 64'({lock_err, req_ready}), 64'h0);
        end
        cyc(); #1 check("to_err", 64'({lock_err, req_ready}), 64'h6);
        cyc(); req_valid = 2'b00;
        #1 check("to_err_once", 64'({lock_err, sfr_ren}), 64'h1);

        // Clock enable low during RDWAIT
        cyc(); sys_clk_en = 1'b0;
        for (int k = 0; k < 3; k++) begin
            #1 check("en_gate", 64'({rsp_valid, sfr_wen, sfr_ren, lock_err}), 64'h0);
            cyc();
        end
        sys_clk_en = 1'b1;
        #1 check("en_rspv", 64'(rsp_valid), 64'h2);
        check("en_rdata", 64'(rsp_rdata), 64'h12345678);

        // Reset during ACCESS drops the transaction
        cyc(); req_valid = 2'b01; req_we = 2'b01; req_addr = 16'h0070; req_wdata = {32'h0, 32'h77};
        #1 check("rs_ready", 64'(req_ready), 64'h1);
        cyc(); req_valid = 2'b00; sys_rst = 1'b1;
        #1 check("rs_norsp", 64'({rsp_valid, sfr_wen}), 64'h0);
        cyc(); sys_rst = 1'b0;
        #1 check_all_zero("rs_after");
        req_valid = 2'b11; req_we = 2'b11; req_addr = 16'h0000;
        #1 check("rs_rr_first", 64'(req_ready), 64'h1);
        cyc(); req_valid = 2'b00;
        #1 check("rs_rspv", 64'(rsp_valid), 64'h1);
        cyc();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
